// File: rtl/branch_lookup_8085_pkg.sv
// Shared constants, helpers and types for the 8085 branch-target lookup table.
package branch_lookup_8085_pkg;

    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_INC   = 2'd1,
        UPD_DEC   = 2'd2,
        UPD_ALLOC = 2'd3
    } upd_kind_e;

    function automatic int unsigned idx_w(input int unsigned entries);
        return (entries < 32'd2) ? 32'd1 : $clog2(entries);
    endfunction

    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Weakly-taken starting point: only the MSB set.
    function automatic logic [31:0] cnt_init(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        return (val >= cnt_max(w)) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/branch_lookup_8085_sat_counter.sv
// Saturating up/down counter with clear and load, used for confidence and statistics.
module sat_counter
    import branch_lookup_8085_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: clear beats load beats increment beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = W'(sat_inc(32'(cnt_q), W));
        end else if (dec_i) begin
            cnt_d = (cnt_q == '0) ? cnt_q : (cnt_q - W'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_lookup_8085.sv
// Fully associative branch-target table: combinational fetch lookup, registered
// execute-stage updates with confidence counters, round-robin replacement and statistics.
module branch_lookup_8085
    import branch_lookup_8085_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [PC_W-1:0]   lk_target,
    input  logic              up_valid,
    input  logic [PC_W-1:0]   up_pc,
    input  logic              up_taken,
    input  logic [PC_W-1:0]   up_target,
    output logic              up_mispredict,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misp
);

    localparam int unsigned IDX_W = idx_w(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [PC_W-1:0]    tag_q    [ENTRIES];
    logic [PC_W-1:0]    tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [IDX_W-1:0]   rp_q, rp_d;
    logic               misp_q;
    logic [CNT_W-1:0]   cnt_s    [ENTRIES];

    logic               lk_hit_s, up_hit_s, free_any_s, misp_s, up_cnt_taken_s;
    logic [IDX_W-1:0]   lk_idx_s, up_idx_s, free_idx_s, alloc_idx_s;
    upd_kind_e          upd_kind_s;

    // Lowest-index match for both ports, plus the lowest free slot.
    always_comb begin
        lk_hit_s   = 1'b0;
        lk_idx_s   = '0;
        up_hit_s   = 1'b0;
        up_idx_s   = '0;
        free_any_s = 1'b0;
        free_idx_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!lk_hit_s && valid_q[i] && (tag_q[i] == lk_pc)) begin
                lk_hit_s = 1'b1;
                lk_idx_s = IDX_W'(i);
            end else begin
                lk_hit_s = lk_hit_s;
            end
            if (!up_hit_s && valid_q[i] && (tag_q[i] == up_pc)) begin
                up_hit_s = 1'b1;
                up_idx_s = IDX_W'(i);
            end else begin
                up_hit_s = up_hit_s;
            end
            if (!free_any_s && !valid_q[i]) begin
                free_any_s = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_any_s = free_any_s;
            end
        end
    end

    assign lk_hit    = lk_hit_s;
    assign lk_taken  = lk_hit_s && (cnt_s[lk_idx_s] >= CNT_INIT);
    assign lk_target = lk_taken ? target_q[lk_idx_s] : (lk_pc + PC_W'(1));

    assign up_cnt_taken_s = cnt_s[up_idx_s] >= CNT_INIT;
    assign alloc_idx_s    = free_any_s ? free_idx_s : rp_q;

    // Mispredict judged against the table as it stands before this update.
    always_comb begin
        misp_s = 1'b0;
        if (up_valid) begin
            if (up_hit_s) begin
                misp_s = (up_cnt_taken_s != up_taken) ||
                         (up_taken && (target_q[up_idx_s] != up_target));
            end else begin
                misp_s = up_taken;
            end
        end else begin
            misp_s = 1'b0;
        end
    end

    // Classify the update; a flush discards it.
    always_comb begin
        upd_kind_s = UPD_NONE;
        if (up_valid && !flush) begin
            if (up_hit_s) begin
                upd_kind_s = up_taken ? UPD_INC : UPD_DEC;
            end else if (up_taken) begin
                upd_kind_s = UPD_ALLOC;
            end else begin
                upd_kind_s = UPD_NONE;
            end
        end else begin
            upd_kind_s = UPD_NONE;
        end
    end

    // Table next state; rp only advances when a valid entry is evicted.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        rp_d     = rp_q;
        if (flush) begin
            valid_d = '0;
            rp_d    = '0;
        end else begin
            case (upd_kind_s)
                UPD_ALLOC: begin
                    valid_d[alloc_idx_s]  = 1'b1;
                    tag_d[alloc_idx_s]    = up_pc;
                    target_d[alloc_idx_s] = up_target;
                    if (!free_any_s) begin
                        rp_d = rp_q + IDX_W'(1);
                    end else begin
                        rp_d = rp_q;
                    end
                end
                UPD_INC: target_d[up_idx_s] = up_target;
                default: rp_d = rp_q;
            endcase
        end
    end

    // Table, pointer and mispredict flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            rp_q    <= '0;
            misp_q  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            rp_q     <= rp_d;
            misp_q   <= misp_s;
        end
    end

    assign up_mispredict = misp_q;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (flush),
            .load_i     ((upd_kind_s == UPD_ALLOC) && (alloc_idx_s == IDX_W'(g))),
            .load_val_i (CNT_INIT),
            .inc_i      ((upd_kind_s == UPD_INC) && (up_idx_s == IDX_W'(g))),
            .dec_i      ((upd_kind_s == UPD_DEC) && (up_idx_s == IDX_W'(g))),
            .cnt_o      (cnt_s[g])
        );
    end

    sat_counter #(.W(STAT_W)) u_stat_hits (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ({STAT_W{1'b0}}),
        .inc_i      (lk_hit_s),
        .dec_i      (1'b0),
        .cnt_o      (stat_hits)
    );

    sat_counter #(.W(STAT_W)) u_stat_misp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ({STAT_W{1'b0}}),
        .inc_i      (misp_s),
        .dec_i      (1'b0),
        .cnt_o      (stat_misp)
    );

endmodule

// File: tb/tb_branch_lookup_8085.sv
// Directed plus random stimulus for branch_lookup_8085, checked against a table-level model.
module tb_branch_lookup_8085;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, up_valid, up_taken;
    logic [7:0] lk_pc, up_pc, up_target;

    logic        lk_hit_a, lk_taken_a, up_misp_a;
    logic [7:0]  lk_target_a;
    logic [15:0] stat_hits_a, stat_misp_a;
    logic        lk_hit_b, lk_taken_b, up_misp_b;
    logic [7:0]  lk_target_b;
    logic [1:0]  stat_hits_b, stat_misp_b;

    branch_lookup_8085 #(.PC_W(8), .ENTRIES(4), .CNT_W(2), .STAT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .lk_pc(lk_pc),
        .lk_hit(lk_hit_a), .lk_taken(lk_taken_a), .lk_target(lk_target_a),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
        .up_mispredict(up_misp_a), .stat_hits(stat_hits_a), .stat_misp(stat_misp_a)
    );

    branch_lookup_8085 #(.PC_W(8), .ENTRIES(4), .CNT_W(2), .STAT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .lk_pc(lk_pc),
        .lk_hit(lk_hit_b), .lk_taken(lk_taken_b), .lk_target(lk_target_b),
        .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
        .up_mispredict(up_misp_b), .stat_hits(stat_hits_b), .stat_misp(stat_misp_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain table of entries, counters as integers 0..3.
    bit m_valid [N];
    int m_tag   [N];
    int m_tgt   [N];
    int m_cnt   [N];
    int m_rp;
    bit m_misp;
    int m_hits_raw;
    int m_misp_raw;

    function automatic int m_find(input int pc);
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_tag[i] == pc) return i;
        return -1;
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int  e;
        bit  hit, tk;
        int  tgt;
        e   = m_find(int'(lk_pc));
        hit = (e >= 0);
        tk  = hit && (m_cnt[e] >= 2);
        tgt = tk ? m_tgt[e] : ((int'(lk_pc) + 1) % 256);
        chk("lk_hit",      32'(lk_hit_a),    32'(hit));
        chk("lk_taken",    32'(lk_taken_a),  32'(tk));
        chk("lk_target",   32'(lk_target_a), 32'(tgt));
        chk("up_misp",     32'(up_misp_a),   32'(m_misp));
        chk("stat_hits",   32'(stat_hits_a), 32'(sat(m_hits_raw, 65535)));
        chk("stat_misp",   32'(stat_misp_a), 32'(sat(m_misp_raw, 65535)));
        chk("b_lk_hit",    32'(lk_hit_b),    32'(hit));
        chk("b_stat_hits", 32'(stat_hits_b), 32'(sat(m_hits_raw, 3)));
        chk("b_stat_misp", 32'(stat_misp_b), 32'(sat(m_misp_raw, 3)));
    endtask

    task automatic model_edge();
        int le, ue, slot;
        bit misp;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
            end
            m_rp = 0; m_misp = 1'b0; m_hits_raw = 0; m_misp_raw = 0;
            return;
        end
        le = m_find(int'(lk_pc));
        ue = m_find(int'(up_pc));
        if (le >= 0) m_hits_raw++;
        if (!up_valid)   misp = 1'b0;
        else if (ue >= 0) misp = ((m_cnt[ue] >= 2) != up_taken) ||
                                 (up_taken && m_tgt[ue] != int'(up_target));
        else             misp = up_taken;
        m_misp = misp;
        if (misp) m_misp_raw++;
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_rp = 0;
        end else if (up_valid) begin
            if (ue >= 0) begin
                if (up_taken) begin
                    m_cnt[ue] = (m_cnt[ue] < 3) ? m_cnt[ue] + 1 : 3;
                    m_tgt[ue] = int'(up_target);
                end else begin
                    m_cnt[ue] = (m_cnt[ue] > 0) ? m_cnt[ue] - 1 : 0;
                end
            end else if (up_taken) begin
                slot = -1;
                for (int i = 0; i < N; i++)
                    if (!m_valid[i] && slot < 0) slot = i;
                if (slot < 0) begin
                    slot = m_rp;
                    m_rp = (m_rp + 1) % N;
                end
                m_valid[slot] = 1'b1;
                m_tag[slot]   = int'(up_pc);
                m_tgt[slot]   = int'(up_target);
                m_cnt[slot]   = 2;
            end
        end
    endtask

    task automatic drive(input logic rn, input logic fl, input logic [7:0] lpc,
                         input logic uv, input logic [7:0] upc, input logic ut,
                         input logic [7:0] utgt);
        rst_n = rn; flush = fl; lk_pc = lpc;
        up_valid = uv; up_pc = upc; up_taken = ut; up_target = utgt;
        #1;
    endtask

    task automatic tick();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cyc(input logic rn, input logic fl, input logic [7:0] lpc,
                       input logic uv, input logic [7:0] upc, input logic ut,
                       input logic [7:0] utgt);
        drive(rn, fl, lpc, uv, upc, ut, utgt);
        tick();
    endtask

    initial begin
        logic       r_rn, r_fl, r_uv, r_ut;
        logic [7:0] r_lpc, r_upc, r_tgt;

        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        cyc(1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00);

        drive(1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rst_hit",  32'(lk_hit_a),    32'd0);
        chk("rst_tgt",  32'(lk_target_a), 32'h11);
        chk("rst_stat", 32'(stat_hits_a), 32'd0);
        tick();

        drive(1'b1, 1'b0, 8'h05, 1'b1, 8'h05, 1'b1, 8'h20);
        chk("same_cycle_miss", 32'(lk_hit_a), 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("alloc_hit",   32'(lk_hit_a),    32'd1);
        chk("alloc_taken", 32'(lk_taken_a),  32'd1);
        chk("alloc_tgt",   32'(lk_target_a), 32'h20);
        chk("alloc_misp",  32'(up_misp_a),   32'd1);
        tick();

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h05, 1'b1, 8'h05, 1'b1, 8'h20);
        drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("sat_misp", 32'(up_misp_a), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 8'h05, 1'b1, 8'h05, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("nt_taken", 32'(lk_taken_a),  32'd0);
        chk("nt_tgt",   32'(lk_target_a), 32'h06);
        chk("nt_misp",  32'(up_misp_a),   32'd1);
        tick();

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int p = 1; p <= 4; p++)
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'(p), 1'b1, 8'(8'h40 + p));
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h45);
        drive(1'b1, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("evict_pc1", 32'(lk_hit_a), 32'd0);
        tick();
        drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("new_pc5", 32'(lk_hit_a), 32'd1);
        tick();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h46);
        drive(1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("evict_pc2", 32'(lk_hit_a), 32'd0);
        tick();

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("hits_sat2", 32'(stat_hits_b), 32'd3);
        chk("wrap_tgt",  32'(lk_target_a), 32'h00);
        tick();

        cyc(1'b1, 1'b1, 8'h03, 1'b1, 8'h07, 1'b1, 8'h77);
        drive(1'b1, 1'b0, 8'h07, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("flush_pc7",  32'(lk_hit_a),  32'd0);
        chk("flush_misp", 32'(up_misp_a), 32'd1);
        tick();
        drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("flush_pc5", 32'(lk_hit_a), 32'd0);
        tick();

        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 1'b1, 8'h99);
        drive(1'b1, 1'b0, 8'h09, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rst_hits", 32'(stat_hits_a), 32'd0);
        chk("rst_misp", 32'(stat_misp_a), 32'd0);
        chk("rst_pc9",  32'(lk_hit_a),    32'd0);
        tick();

        for (int i = 0; i < 400; i++) begin
            r_rn  = ($urandom_range(0, 99) != 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_lpc = 8'($urandom_range(0, 7));
            r_uv  = ($urandom_range(0, 1) == 1);
            r_upc = 8'($urandom_range(0, 7));
            r_ut  = ($urandom_range(0, 2) != 0);
            r_tgt = 8'(8'h30 + $urandom_range(0, 1));
            cyc(r_rn, r_fl, r_lpc, r_uv, r_upc, r_ut, r_tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
